// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle controller: opcode fields, FSM states,
// ALU operations, datapath mux encodings and the ALU-instruction decoder.
package controller_pkg;

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_ANDI  = 4'b0001;
   localparam logic [3:0] OP_ORI   = 4'b0010;
   localparam logic [3:0] OP_XORI  = 4'b0011;
   localparam logic [3:0] OP_MEMJ  = 4'b0100;
   localparam logic [3:0] OP_ADDI  = 4'b0101;
   localparam logic [3:0] OP_SHIFT = 4'b1000;
   localparam logic [3:0] OP_SUBI  = 4'b1001;
   localparam logic [3:0] OP_CMPI  = 4'b1011;
   localparam logic [3:0] OP_BCOND = 4'b1100;
   localparam logic [3:0] OP_MOVI  = 4'b1101;
   localparam logic [3:0] OP_LUI   = 4'b1111;

   localparam logic [3:0] EXT_AND   = 4'b0001;
   localparam logic [3:0] EXT_OR    = 4'b0010;
   localparam logic [3:0] EXT_XOR   = 4'b0011;
   localparam logic [3:0] EXT_ADD   = 4'b0101;
   localparam logic [3:0] EXT_SUB   = 4'b1001;
   localparam logic [3:0] EXT_CMP   = 4'b1011;
   localparam logic [3:0] EXT_MOV   = 4'b1101;
   localparam logic [3:0] EXT_LSH   = 4'b0100;
   localparam logic [3:0] EXT_LOAD  = 4'b0000;
   localparam logic [3:0] EXT_STOR  = 4'b0100;
   localparam logic [3:0] EXT_JCOND = 4'b1100;
   localparam logic [3:0] EXT_JAL   = 4'b1000;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXECUTE, S_WRITE, S_LOAD,
      S_STORE, S_BRANCH, S_JUMP, S_LINK, S_TRAP
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_PASS_A, ALU_LSH, ALU_LUI
   } alu_op_t;

   localparam logic [1:0] A_PC       = 2'b00;
   localparam logic [1:0] A_SRC      = 2'b01;
   localparam logic [1:0] A_IMM_SEXT = 2'b10;
   localparam logic [1:0] A_IMM_ZEXT = 2'b11;
   localparam logic [1:0] B_DST      = 2'b00;
   localparam logic [1:0] B_ONE      = 2'b01;
   localparam logic [1:0] B_PC       = 2'b10;
   localparam logic [1:0] WSEL_ALU   = 2'b00;
   localparam logic [1:0] WSEL_MEM   = 2'b01;
   localparam logic [1:0] WSEL_PC    = 2'b10;
   localparam logic       ADDR_PC    = 1'b0;
   localparam logic       ADDR_DST   = 1'b1;

   typedef struct packed {
      logic [1:0] a_sel;
      logic [1:0] b_sel;
      alu_op_t    op;
      logic       flags_we;
      logic       is_cmp;
      logic       valid;
   } alu_ctrl_t;

   // ALU selects for every instruction that goes through EXECUTE; valid=0 otherwise.
   function automatic alu_ctrl_t decode_alu(input logic [3:0] opc, input logic [3:0] ext);
      alu_ctrl_t d;
      d.a_sel    = A_SRC;
      d.b_sel    = B_DST;
      d.op       = ALU_ADD;
      d.flags_we = 1'b0;
      d.is_cmp   = 1'b0;
      d.valid    = 1'b1;
      case (opc)
         OP_RTYPE: begin
            case (ext)
               EXT_ADD: d.flags_we = 1'b1;
               EXT_SUB: begin d.op = ALU_SUB; d.flags_we = 1'b1; end
               EXT_CMP: begin d.op = ALU_SUB; d.flags_we = 1'b1; d.is_cmp = 1'b1; end
               EXT_AND: d.op = ALU_AND;
               EXT_OR:  d.op = ALU_OR;
               EXT_XOR: d.op = ALU_XOR;
               EXT_MOV: d.op = ALU_PASS_A;
               default: d.valid = 1'b0;
            endcase
         end
         OP_SHIFT: begin d.op = ALU_LSH; d.valid = (ext == EXT_LSH); end
         OP_ANDI:  begin d.a_sel = A_IMM_ZEXT; d.op = ALU_AND; end
         OP_ORI:   begin d.a_sel = A_IMM_ZEXT; d.op = ALU_OR; end
         OP_XORI:  begin d.a_sel = A_IMM_ZEXT; d.op = ALU_XOR; end
         OP_ADDI:  begin d.a_sel = A_IMM_SEXT; d.flags_we = 1'b1; end
         OP_SUBI:  begin d.a_sel = A_IMM_SEXT; d.op = ALU_SUB; d.flags_we = 1'b1; end
         OP_CMPI:  begin d.a_sel = A_IMM_SEXT; d.op = ALU_SUB; d.flags_we = 1'b1; d.is_cmp = 1'b1; end
         OP_MOVI:  begin d.a_sel = A_IMM_SEXT; d.op = ALU_PASS_A; end
         OP_LUI:   begin d.a_sel = A_IMM_ZEXT; d.op = ALU_LUI; end
         default:  d.valid = 1'b0;
      endcase
      return d;
   endfunction

   // DECODE successor; S_TRAP marks an undecoded instruction.
   function automatic state_t decode_next(input logic [3:0] opc, input logic [3:0] ext);
      state_t s;
      s = S_TRAP;
      if (decode_alu(opc, ext).valid) s = S_EXECUTE;
      else if (opc == OP_BCOND) s = S_BRANCH;
      else if (opc == OP_MEMJ) begin
         case (ext)
            EXT_LOAD:  s = S_LOAD;
            EXT_STOR:  s = S_STORE;
            EXT_JCOND: s = S_JUMP;
            EXT_JAL:   s = S_LINK;
            default:   s = S_TRAP;
         endcase
      end
      return s;
   endfunction

endpackage

// File: rtl/memory_wait_counter.sv
// Wait-state counter for memory reads; last_cycle_o marks the cycle on which
// read data is valid. Cleared whenever the controller changes state.
module memory_wait_counter #(
   parameter int unsigned MEM_WAIT_CYCLES = 0
) (
   input  logic clock,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic last_cycle_o
);
   logic [3:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i)       count_d = 4'd0;
      else if (enable_i) count_d = count_q + 4'd1;
   end

   always_ff @(posedge clock) begin
      if (!reset) count_q <= 4'd0;
      else        count_q <= count_d;
   end

   assign last_cycle_o = (count_q == 4'(MEM_WAIT_CYCLES));
endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the 16-bit CPU: decodes the instruction register
// and drives datapath selects/enables. CONTROLLER_TRAP_EN enables the TRAP state.
module multicycle_controller
   import controller_pkg::*;
#(
   parameter int unsigned MEM_WAIT_CYCLES     = 0,
   parameter int unsigned ALU_OPERATION_WIDTH = 3
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [3:0]                     instruction_operation,
   input  logic [3:0]                     instruction_operation_extra,
   input  logic                           condition_met,
   output logic [1:0]                     alu_a_select,
   output logic [1:0]                     alu_b_select,
   output logic [ALU_OPERATION_WIDTH-1:0] alu_operation,
   output logic                           address_select,
   output logic                           program_counter_write_enable,
   output logic                           program_counter_select,
   output logic                           instruction_write_enable,
   output logic                           register_write_enable,
   output logic [1:0]                     register_write_select,
   output logic                           flags_write_enable,
   output logic                           memory_write_enable,
   output logic                           illegal_instruction
);
`ifdef CONTROLLER_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   state_t    state_q, state_d, decoded;
   alu_ctrl_t alu_c;
   logic      last_cycle;

   assign alu_c   = decode_alu(instruction_operation, instruction_operation_extra);
   assign decoded = decode_next(instruction_operation, instruction_operation_extra);

   memory_wait_counter #(.MEM_WAIT_CYCLES(MEM_WAIT_CYCLES)) u_wait (
      .clock        (clock),
      .reset        (reset),
      .clear_i      (state_d != state_q),
      .enable_i     ((state_q == S_FETCH) || (state_q == S_LOAD)),
      .last_cycle_o (last_cycle)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:   if (last_cycle) state_d = S_DECODE;
         S_DECODE:  state_d = (decoded == S_TRAP && !TRAP_EN) ? S_FETCH : decoded;
         S_EXECUTE: state_d = alu_c.is_cmp ? S_FETCH : S_WRITE;
         S_LOAD:    if (last_cycle) state_d = S_FETCH;
         S_TRAP:    state_d = S_TRAP;
         default:   state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   logic [1:0] a_sel, b_sel, wsel;
   logic [2:0] op;
   logic       addr, pc_we, pc_sel, ir_we, reg_we, flags_we, mem_we, ill;

   always_comb begin
      a_sel = A_PC;  b_sel = B_DST;  op = ALU_ADD;  wsel = WSEL_ALU;
      addr = ADDR_PC;  pc_we = 1'b0;  pc_sel = 1'b0;  ir_we = 1'b0;
      reg_we = 1'b0;  flags_we = 1'b0;  mem_we = 1'b0;  ill = 1'b0;
      case (state_q)
         S_FETCH: if (last_cycle) begin
            a_sel = A_PC;  b_sel = B_ONE;  op = ALU_ADD;
            ir_we = 1'b1;  pc_we = 1'b1;
         end
         S_EXECUTE: begin
            a_sel = alu_c.a_sel;  b_sel = alu_c.b_sel;  op = alu_c.op;
            flags_we = alu_c.flags_we;
         end
         S_WRITE: begin
            a_sel = alu_c.a_sel;  b_sel = alu_c.b_sel;  op = alu_c.op;
            reg_we = 1'b1;  wsel = WSEL_ALU;
         end
         S_LOAD: begin
            addr = ADDR_DST;
            if (last_cycle) begin reg_we = 1'b1; wsel = WSEL_MEM; end
         end
         S_STORE: begin addr = ADDR_DST; mem_we = 1'b1; end
         // PC already points past the branch, so target = PC + sign-extended displacement.
         S_BRANCH: if (condition_met) begin
            a_sel = A_IMM_SEXT;  b_sel = B_PC;  op = ALU_ADD;  pc_we = 1'b1;
         end
         S_JUMP: if (condition_met) begin pc_we = 1'b1; pc_sel = 1'b1; end
         S_LINK: begin
            reg_we = 1'b1;  wsel = WSEL_PC;  pc_we = 1'b1;  pc_sel = 1'b1;
         end
         S_TRAP:  ill = TRAP_EN;
         default: ;
      endcase
   end

   assign alu_a_select                 = reset ? a_sel : 2'b00;
   assign alu_b_select                 = reset ? b_sel : 2'b00;
   assign alu_operation                = reset ? ALU_OPERATION_WIDTH'(op) : '0;
   assign address_select               = reset & addr;
   assign program_counter_write_enable = reset & pc_we;
   assign program_counter_select       = reset & pc_sel;
   assign instruction_write_enable     = reset & ir_we;
   assign register_write_enable        = reset & reg_we;
   assign register_write_select        = reset ? wsel : 2'b00;
   assign flags_write_enable           = reset & flags_we;
   assign memory_write_enable          = reset & mem_we;
   assign illegal_instruction          = reset & ill;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller: per-cycle output traces
// for W=0 and W=2 instances, reset gating/abort and the illegal-opcode path.
module tb_multicycle_controller;
   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] opc = 4'd0, ext = 4'd0;
   logic       cond = 1'b0;

   logic [1:0] a0, b0, rs0, a2, b2, rs2;
   logic [2:0] o0, o2;
   logic as0, pw0, ps0, iw0, rw0, fw0, mw0, il0;
   logic as2, pw2, ps2, iw2, rw2, fw2, mw2, il2;

   always #5 clock = ~clock;

   multicycle_controller #(.MEM_WAIT_CYCLES(0), .ALU_OPERATION_WIDTH(3)) dut0 (
      .clock(clock), .reset(reset),
      .instruction_operation(opc), .instruction_operation_extra(ext), .condition_met(cond),
      .alu_a_select(a0), .alu_b_select(b0), .alu_operation(o0), .address_select(as0),
      .program_counter_write_enable(pw0), .program_counter_select(ps0),
      .instruction_write_enable(iw0), .register_write_enable(rw0),
      .register_write_select(rs0), .flags_write_enable(fw0),
      .memory_write_enable(mw0), .illegal_instruction(il0));

   multicycle_controller #(.MEM_WAIT_CYCLES(2), .ALU_OPERATION_WIDTH(3)) dut2 (
      .clock(clock), .reset(reset),
      .instruction_operation(opc), .instruction_operation_extra(ext), .condition_met(cond),
      .alu_a_select(a2), .alu_b_select(b2), .alu_operation(o2), .address_select(as2),
      .program_counter_write_enable(pw2), .program_counter_select(ps2),
      .instruction_write_enable(iw2), .register_write_enable(rw2),
      .register_write_select(rs2), .flags_write_enable(fw2),
      .memory_write_enable(mw2), .illegal_instruction(il2));

   wire [16:0] obs0 = {a0, b0, o0, as0, pw0, ps0, iw0, rw0, rs0, fw0, mw0, il0};
   wire [16:0] obs2 = {a2, b2, o2, as2, pw2, ps2, iw2, rw2, rs2, fw2, mw2, il2};

   int checks = 0;
   int failures = 0;
   logic [16:0] exp_q[$];

   function automatic logic [16:0] mk(input int a, b, o, as, pw, ps, iw, rw, rs, fw, mw, il);
      return {a[1:0], b[1:0], o[2:0], as[0], pw[0], ps[0], iw[0], rw[0], rs[1:0], fw[0], mw[0], il[0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reset for one edge, checking forced-zero outputs; returns just after release.
   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rst_w0", {15'd0, obs0}, 32'd0);
      chk("rst_w2", {15'd0, obs2}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      #1;
   endtask

   task automatic run(input string tag, input bit w2, input logic [3:0] o, input logic [3:0] e,
                      input logic c);
      opc = o; ext = e; cond = c;
      do_reset();
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i > 0) begin @(negedge clock); #1; end
         chk($sformatf("%s[%0d]", tag, i), {15'd0, w2 ? obs2 : obs0}, {15'd0, exp_q[i]});
      end
      exp_q.delete();
   endtask

   logic [16:0] FL, Z, ILL;

   initial begin
      FL  = mk(0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      Z   = 17'd0;
      ILL = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

      exp_q = '{FL, Z, mk(1,0,0,0,0,0,0,0,0,1,0,0), mk(1,0,0,0,0,0,0,1,0,0,0,0), FL};
      run("add_w0", 1'b0, 4'b0000, 4'b0101, 1'b0);

      exp_q = '{FL, Z, mk(2,0,1,0,0,0,0,0,0,1,0,0), FL};
      run("cmpi_w0", 1'b0, 4'b1011, 4'b0000, 1'b0);

      exp_q = '{FL, Z, mk(1,0,1,0,0,0,0,0,0,1,0,0), FL};
      run("cmp_w0", 1'b0, 4'b0000, 4'b1011, 1'b0);

      exp_q = '{FL, Z, mk(3,0,2,0,0,0,0,0,0,0,0,0), mk(3,0,2,0,0,0,0,1,0,0,0,0), FL};
      run("andi_w0", 1'b0, 4'b0001, 4'b0000, 1'b0);

      exp_q = '{FL, Z, mk(3,0,7,0,0,0,0,0,0,0,0,0), mk(3,0,7,0,0,0,0,1,0,0,0,0), FL};
      run("lui_w0", 1'b0, 4'b1111, 4'b0000, 1'b0);

      exp_q = '{FL, Z, mk(1,0,6,0,0,0,0,0,0,0,0,0), mk(1,0,6,0,0,0,0,1,0,0,0,0), FL};
      run("lsh_w0", 1'b0, 4'b1000, 4'b0100, 1'b0);

      exp_q = '{Z, Z, FL, Z, mk(0,0,0,1,0,0,0,0,0,0,0,0), mk(0,0,0,1,0,0,0,0,0,0,0,0),
                mk(0,0,0,1,0,0,0,1,1,0,0,0), Z};
      run("load_w2", 1'b1, 4'b0100, 4'b0000, 1'b0);

      exp_q = '{Z, Z, FL, Z, mk(1,0,0,0,0,0,0,0,0,1,0,0), mk(1,0,0,0,0,0,0,1,0,0,0,0), Z, Z, FL};
      run("add_w2", 1'b1, 4'b0000, 4'b0101, 1'b0);

      exp_q = '{FL, Z, mk(0,0,0,1,0,0,0,0,0,0,1,0), FL};
      run("store_w0", 1'b0, 4'b0100, 4'b0100, 1'b0);

      exp_q = '{FL, Z, Z, FL};
      run("bcc_nt", 1'b0, 4'b1100, 4'b0000, 1'b0);

      exp_q = '{FL, Z, mk(2,2,0,0,1,0,0,0,0,0,0,0), FL};
      run("bcc_t", 1'b0, 4'b1100, 4'b0000, 1'b1);

      exp_q = '{FL, Z, mk(0,0,0,0,1,1,0,0,0,0,0,0), FL};
      run("jcond_t", 1'b0, 4'b0100, 4'b1100, 1'b1);

      exp_q = '{FL, Z, Z, FL};
      run("jcond_nt", 1'b0, 4'b0100, 4'b1100, 1'b0);

      exp_q = '{FL, Z, mk(0,0,0,0,1,1,0,1,2,0,0,0), FL};
      run("jal_w0", 1'b0, 4'b0100, 4'b1000, 1'b0);

      // Abort in EXECUTE: the reset edge lands in WRITE, whose enables must be gated.
      exp_q = '{FL, Z, mk(1,0,0,0,0,0,0,0,0,1,0,0)};
      run("abort", 1'b0, 4'b0000, 4'b0101, 1'b0);
      do_reset();
      chk("abort_post", {15'd0, obs0}, {15'd0, FL});

`ifdef CONTROLLER_TRAP_EN
      exp_q = '{FL, Z, ILL, ILL, ILL, ILL};
`else
      exp_q = '{FL, Z, FL, Z, FL};
`endif
      run("illegal", 1'b0, 4'b1000, 4'b0000, 1'b0);

      exp_q = '{FL, Z, mk(2,0,5,0,0,0,0,0,0,0,0,0)};
      run("movi_post_ill", 1'b0, 4'b1101, 4'b0000, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
